// File: rtl/seg_disp_pkg.sv
// Shared constants for the seven-segment display arbiter: nibble codes,
// banner words and the arbiter state encoding.
package seg_disp_pkg;

  localparam logic [3:0] CODE_E     = 4'hA;
  localparam logic [3:0] CODE_N     = 4'hB;
  localparam logic [3:0] CODE_D     = 4'hC;
  localparam logic [3:0] CODE_DASH  = 4'hD;
  localparam logic [3:0] CODE_BLANK = 4'hE;

  localparam logic [31:0] DISP_IDLE = {8{CODE_DASH}};
  // Five blanks followed by "End", right-aligned on the display.
  localparam logic [31:0] DISP_END  = {{5{CODE_BLANK}}, CODE_E, CODE_N, CODE_D};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// start_idx (wrapping) whose request is set and not masked by excl.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start_idx,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0]    cand_idx [N_REQ];
  logic [N_REQ-1:0] hit;

  // Candidate gi is the gi-th position in search order from start_idx.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, start_idx} + (IW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
    assign hit[gi]      = req[cand_idx[gi]] & ~excl[cand_idx[gi]];
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 8-digit display with minimum dwell per owner,
// dash pattern when idle and a sticky "End" banner once the CPU halts.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [32*N_REQ-1:0]       req_value,
  input  logic                      halt,
  output logic [N_REQ-1:0]          grant,
  output logic [$clog2(N_REQ)-1:0]  owner_idx,
  output logic [31:0]               disp_value,
  output logic                      halted
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [31:0]      disp_reg, disp_next;
  logic             halted_reg, halted_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [IW-1:0]    start_idx;
  logic [N_REQ-1:0] excl_mask;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;

  // Search always begins just after the current/last owner; while owning,
  // the owner itself is excluded so a rotation never re-picks it.
  assign start_idx = (owner_reg == IW'(N_REQ - 1)) ? '0 : owner_reg + IW'(1);
  assign excl_mask = (state_reg == OWNED) ? (N_REQ'(1) << owner_reg) : '0;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req       (req),
    .start_idx (start_idx),
    .excl      (excl_mask),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      owner_reg  <= IW'(N_REQ - 1);
      disp_reg   <= DISP_IDLE;
      halted_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      owner_reg  <= owner_next;
      disp_reg   <= disp_next;
      halted_reg <= halted_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    owner_next  = owner_reg;
    disp_next   = disp_reg;
    halted_next = halted_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (halt) begin
          state_next  = HALTED;
          grant_next  = '0;
          disp_next   = DISP_END;
          halted_next = 1'b1;
          cnt_next    = '0;
        end else if (pick_found) begin
          state_next = OWNED;
          grant_next = N_REQ'(1) << pick_idx;
          owner_next = pick_idx;
          disp_next  = req_value[32*pick_idx +: 32];
          cnt_next   = CNT_LOAD;
        end else begin
          grant_next = '0;
          disp_next  = DISP_IDLE;
        end
      end

      OWNED: begin
        if (halt) begin
          state_next  = HALTED;
          grant_next  = '0;
          disp_next   = DISP_END;
          halted_next = 1'b1;
          cnt_next    = '0;
        end else if ((!req[owner_reg] || cnt_reg == '0) && pick_found) begin
          // Released owner or expired dwell with someone else waiting.
          grant_next = N_REQ'(1) << pick_idx;
          owner_next = pick_idx;
          disp_next  = req_value[32*pick_idx +: 32];
          cnt_next   = CNT_LOAD;
        end else if (!req[owner_reg]) begin
          state_next = IDLE;
          grant_next = '0;
          disp_next  = DISP_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next  = (cnt_reg == '0) ? '0 : cnt_reg - CW'(1);
          disp_next = req_value[32*owner_reg +: 32];
        end
      end

      HALTED: begin
        grant_next  = '0;
        disp_next   = DISP_END;
        halted_next = 1'b1;
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
        disp_next  = DISP_IDLE;
      end
    endcase
  end

  assign grant      = grant_reg;
  assign owner_idx  = owner_reg;
  assign disp_value = disp_reg;
  assign halted     = halted_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with N_REQ=4, HOLD_CYCLES=4.
module tb_seg_display_arbiter;

  localparam int N = 4;
  localparam logic [31:0] E_IDLE = 32'hDDDD_DDDD;
  localparam logic [31:0] E_END  = 32'hEEEE_EABC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [127:0]  req_value = '0;
  logic          halt = 1'b0;
  logic [N-1:0]  grant;
  logic [1:0]    owner_idx;
  logic [31:0]   disp_value;
  logic          halted;

  int n_vec = 0;
  int n_err = 0;

  seg_display_arbiter #(
    .N_REQ       (N),
    .HOLD_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_value  (req_value),
    .halt       (halt),
    .grant      (grant),
    .owner_idx  (owner_idx),
    .disp_value (disp_value),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; halt = 1'b0; req_value = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
    n_vec++; if (disp_value !== E_IDLE) begin n_err++; $display("FAIL reset_disp got=%h exp=%h", disp_value, E_IDLE); end
    n_vec++; if (owner_idx !== 2'd3) begin n_err++; $display("FAIL reset_owner got=%0d exp=3", owner_idx); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", halted); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++; if (grant !== 4'b0000 || disp_value !== E_IDLE) begin n_err++; $display("FAIL idle_noreq grant=%b disp=%h exp grant=0000 disp=%h", grant, disp_value, E_IDLE); end
    $display("test_reset done: vectors=%0d", n_vec);
  endtask

  task automatic test_rotate();
    logic [N-1:0] exp_g [12];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100,
              4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    do_reset();
    req_value[31:0]  = 32'h0000_1234;
    req_value[95:64] = 32'h00BE_EF00;
    req = 4'b0101;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_vec++;
      if (grant !== exp_g[c] ||
          disp_value !== ((exp_g[c] == 4'b0001) ? 32'h0000_1234 : 32'h00BE_EF00)) begin
        n_err++;
        $display("FAIL rotate_c%0d grant=%b disp=%h exp grant=%b", c, grant, disp_value, exp_g[c]);
      end
    end
    $display("test_rotate done: vectors=%0d", n_vec);
  endtask

  task automatic test_single_owner();
    do_reset();
    req_value[127:96] = 32'hCAFE_0003;
    req = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if (grant !== 4'b1000 || owner_idx !== 2'd3) begin
        n_err++;
        $display("FAIL single_hold_c%0d grant=%b owner=%0d exp grant=1000 owner=3", c, grant, owner_idx);
      end
    end
    req_value[127:96] = 32'h0000_0005;
    #1;
    n_vec++; if (disp_value !== 32'hCAFE_0003) begin n_err++; $display("FAIL single_lag got=%h exp=cafe0003", disp_value); end
    tick();
    n_vec++; if (disp_value !== 32'h0000_0005) begin n_err++; $display("FAIL single_track got=%h exp=00000005", disp_value); end
    $display("test_single_owner done: vectors=%0d", n_vec);
  endtask

  task automatic test_drop();
    do_reset();
    req_value[31:0]  = 32'h0000_00A0;
    req_value[63:32] = 32'h0000_00B1;
    req = 4'b0011;
    tick();
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL drop_first grant=%b exp=0001", grant); end
    tick();
    req = 4'b0010;
    tick();
    n_vec++; if (grant !== 4'b0010 || disp_value !== 32'h0000_00B1) begin n_err++; $display("FAIL drop_handover grant=%b disp=%h exp 0010/000000b1", grant, disp_value); end
    req = 4'b0000;
    tick();
    n_vec++; if (grant !== 4'b0000 || disp_value !== E_IDLE) begin n_err++; $display("FAIL drop_idle grant=%b disp=%h exp 0000/%h", grant, disp_value, E_IDLE); end
    n_vec++; if (owner_idx !== 2'd1) begin n_err++; $display("FAIL drop_owner_hold got=%0d exp=1", owner_idx); end
    $display("test_drop done: vectors=%0d", n_vec);
  endtask

  task automatic test_halt();
    do_reset();
    req_value[31:0]  = 32'h0000_1234;
    req_value[95:64] = 32'h00BE_EF00;
    req = 4'b0101;
    for (int c = 0; c < 4; c++) tick();
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL halt_pre grant=%b exp=0001", grant); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_vec++; if (grant !== 4'b0000 || disp_value !== E_END || halted !== 1'b1) begin
      n_err++; $display("FAIL halt_enter grant=%b disp=%h halted=%b exp 0000/%h/1", grant, disp_value, halted, E_END);
    end
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (grant !== 4'b0000 || disp_value !== E_END || halted !== 1'b1) begin
        n_err++; $display("FAIL halt_sticky_c%0d grant=%b disp=%h halted=%b", c, grant, disp_value, halted);
      end
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (grant !== 4'b0000 || disp_value !== E_IDLE || halted !== 1'b0 || owner_idx !== 2'd3) begin
      n_err++; $display("FAIL halt_reset grant=%b disp=%h halted=%b owner=%0d", grant, disp_value, halted, owner_idx);
    end
    req = '0;
    tick();
    rst_n = 1'b1;
    $display("test_halt done: vectors=%0d", n_vec);
  endtask

  task automatic test_wrap();
    do_reset();
    req_value[31:0]   = 32'h0000_0000;
    req_value[127:96] = 32'h3333_3333;
    req = 4'b1000;
    tick();
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL wrap_owner3 grant=%b exp=1000", grant); end
    req = 4'b1001;
    for (int c = 0; c < 3; c++) tick();
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL wrap_dwell grant=%b exp=1000", grant); end
    tick();
    n_vec++; if (grant !== 4'b0001 || owner_idx !== 2'd0) begin n_err++; $display("FAIL wrap_next grant=%b owner=%0d exp 0001/0", grant, owner_idx); end
    $display("test_wrap done: vectors=%0d", n_vec);
  endtask

  initial begin
    tick();
    test_reset();
    test_rotate();
    test_single_owner();
    test_drop();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
